// File: rtl/lsm_pkg.sv
// Shared types, constants and the saturation helpers used by the normal-equation builder.
package lsm_pkg;

    // Integer bits of every fixed-point word; the fraction takes the rest.
    localparam int Q_INT = 16;

    // Working width for saturation checks; covers any WIDTH up to 64.
    localparam int SAT_W = 128;

    typedef enum logic [1:0] {S_ACCUM, S_DRAIN, S_ISSUE, S_WAIT} neb_state_t;

    // True when a wide signed value does not fit into a signed word of 'width' bits.
    function automatic logic sat_hit(input logic signed [SAT_W-1:0] wide, input int width);
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one = 1;
        hi  = (one <<< (width - 1)) - one;
        lo  = -(one <<< (width - 1));
        return (wide > hi) || (wide < lo);
    endfunction

    // Clamp a wide signed value to [-2^(width-1), 2^(width-1)-1]; caller keeps the low bits.
    function automatic logic signed [63:0] sat_trunc(input logic signed [SAT_W-1:0] wide, input int width);
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] res;
        one = 1;
        hi  = (one <<< (width - 1)) - one;
        lo  = -(one <<< (width - 1));
        if (wide > hi) begin
            res = hi;
        end else if (wide < lo) begin
            res = lo;
        end else begin
            res = wide;
        end
        return res[63:0];
    endfunction

endpackage

// File: rtl/lsm_sat_mul.sv
// Pipelined saturating fixed-point multiplier: full product, rescale, clamp, then MUL_LATENCY registers.
module lsm_sat_mul
    import lsm_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] p,
    output logic                    sat
);
    localparam int QFRAC = WIDTH - Q_INT;

    logic signed [2*WIDTH-1:0] prod_full;
    logic signed [2*WIDTH-1:0] prod_shift;
    logic signed [SAT_W-1:0]   prod_wide;
    logic signed [WIDTH-1:0]   prod_sat;
    logic                      prod_hit;

    // Full-precision product, drop the fraction bits, then clamp to one word.
    always_comb begin
        prod_full  = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        prod_shift = prod_full >>> QFRAC;
        prod_wide  = SAT_W'(prod_shift);
        prod_hit   = sat_hit(prod_wide, WIDTH);
        prod_sat   = WIDTH'(sat_trunc(prod_wide, WIDTH));
    end

    genvar gi;
    generate
        for (gi = 0; gi < MUL_LATENCY; gi++) begin : g_stage
            logic                    v_q;
            logic                    s_q;
            logic signed [WIDTH-1:0] p_q;
            logic                    v_d;
            logic                    s_d;
            logic signed [WIDTH-1:0] p_d;
            if (gi == 0) begin : g_head
                assign v_d = in_valid;
                assign s_d = in_valid & prod_hit;
                assign p_d = prod_sat;
            end else begin : g_tail
                assign v_d = g_stage[gi-1].v_q;
                assign s_d = g_stage[gi-1].s_q;
                assign p_d = g_stage[gi-1].p_q;
            end
            // One register stage of the multiplier pipeline.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    s_q <= 1'b0;
                    p_q <= '0;
                end else begin
                    v_q <= v_d;
                    s_q <= s_d;
                    p_q <= p_d;
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[MUL_LATENCY-1].v_q;
    assign sat       = g_stage[MUL_LATENCY-1].s_q;
    assign p         = g_stage[MUL_LATENCY-1].p_q;

endmodule

// File: rtl/lsm_normal_eq_builder.sv
// Streams (x, y) samples through x^k products, accumulates power sums and hands A/B to the solver.
module lsm_normal_eq_builder
    import lsm_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 1,
    parameter int GUARD       = 8,
    parameter int MAX_SAMPLES = 4096
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic signed [WIDTH-1:0]          s_x,
    input  logic signed [WIDTH-1:0]          s_y,
    input  logic                             s_last,
    output logic [9*WIDTH-1:0]               A_flat,
    output logic [3*WIDTH-1:0]               B_flat,
    output logic                             solve_start,
    input  logic                             solve_done,
    output logic                             busy,
    output logic                             sat_flag,
    output logic [$clog2(MAX_SAMPLES+1)-1:0] sample_count
);
    localparam int QFRAC    = WIDTH - Q_INT;
    localparam int AW       = WIDTH + GUARD;
    localparam int CW       = $clog2(MAX_SAMPLES + 1);
    localparam int PIPE_LAT = 2 * MUL_LATENCY + 1;
    localparam int DW       = $clog2(PIPE_LAT + 1);
    localparam int NSUM     = 7;  // Sx, Sx2, Sx3, Sx4, Sy, Sxy, Sx2y

    neb_state_t              state_q, state_d;
    logic [DW-1:0]           drain_q, drain_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    ready_q, ready_d;
    logic                    start_q, start_d;
    logic                    sat_q, sat_d;
    logic [9*WIDTH-1:0]      a_q, a_d;
    logic [3*WIDTH-1:0]      b_q, b_d;
    logic                    clear_acc;
    logic                    fire;

    logic signed [WIDTH-1:0] x2, xy, x3, x4, x2y;
    logic                    v_x2, v_xy, v_x3, v_x4, v_x2y;
    logic                    sat_x2, sat_xy, sat_x3, sat_x4, sat_x2y;
    logic                    s1_valid, s2_valid, mul_sat;
    logic signed [WIDTH-1:0] x_s2, y_s2, x_s3, y_s3, x2_s3, xy_s3;

    assign fire = s_valid && ready_q;

    // Stage 1: x^2 and x*y straight from the accepted beat.
    lsm_sat_mul #(.WIDTH(WIDTH), .MUL_LATENCY(MUL_LATENCY)) u_mul_x2 (
        .clk(clk), .rst_n(rst_n), .in_valid(fire), .a(s_x), .b(s_x),
        .out_valid(v_x2), .p(x2), .sat(sat_x2));
    lsm_sat_mul #(.WIDTH(WIDTH), .MUL_LATENCY(MUL_LATENCY)) u_mul_xy (
        .clk(clk), .rst_n(rst_n), .in_valid(fire), .a(s_x), .b(s_y),
        .out_valid(v_xy), .p(xy), .sat(sat_xy));
    assign s1_valid = v_x2 && v_xy;

    // Stage 2: higher powers built from the saturated x^2.
    lsm_sat_mul #(.WIDTH(WIDTH), .MUL_LATENCY(MUL_LATENCY)) u_mul_x3 (
        .clk(clk), .rst_n(rst_n), .in_valid(s1_valid), .a(x2), .b(x_s2),
        .out_valid(v_x3), .p(x3), .sat(sat_x3));
    lsm_sat_mul #(.WIDTH(WIDTH), .MUL_LATENCY(MUL_LATENCY)) u_mul_x4 (
        .clk(clk), .rst_n(rst_n), .in_valid(s1_valid), .a(x2), .b(x2),
        .out_valid(v_x4), .p(x4), .sat(sat_x4));
    lsm_sat_mul #(.WIDTH(WIDTH), .MUL_LATENCY(MUL_LATENCY)) u_mul_x2y (
        .clk(clk), .rst_n(rst_n), .in_valid(s1_valid), .a(x2), .b(y_s2),
        .out_valid(v_x2y), .p(x2y), .sat(sat_x2y));
    assign s2_valid = v_x3 && v_x4 && v_x2y;
    assign mul_sat  = sat_x2 | sat_xy | sat_x3 | sat_x4 | sat_x2y;

    genvar gi, gj;
    generate
        // Raw x/y ride alongside both multiplier stages; tapped after stage 1 and stage 2.
        for (gi = 0; gi < 2*MUL_LATENCY; gi++) begin : g_xy_dly
            logic [2*WIDTH-1:0] d_q;
            logic [2*WIDTH-1:0] d_in;
            if (gi == 0) begin : g_src
                assign d_in = {s_x, s_y};
            end else begin : g_chain
                assign d_in = g_xy_dly[gi-1].d_q;
            end
            // Alignment register for the raw sample.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) d_q <= '0;
                else        d_q <= d_in;
            end
        end
        // Stage-1 products wait out stage 2 so all seven terms reach the adders together.
        for (gi = 0; gi < MUL_LATENCY; gi++) begin : g_sq_dly
            logic [2*WIDTH-1:0] d_q;
            logic [2*WIDTH-1:0] d_in;
            if (gi == 0) begin : g_src
                assign d_in = {x2, xy};
            end else begin : g_chain
                assign d_in = g_sq_dly[gi-1].d_q;
            end
            // Alignment register for x^2 and x*y.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) d_q <= '0;
                else        d_q <= d_in;
            end
        end
    endgenerate

    assign x_s2  = g_xy_dly[MUL_LATENCY-1].d_q[2*WIDTH-1:WIDTH];
    assign y_s2  = g_xy_dly[MUL_LATENCY-1].d_q[WIDTH-1:0];
    assign x_s3  = g_xy_dly[2*MUL_LATENCY-1].d_q[2*WIDTH-1:WIDTH];
    assign y_s3  = g_xy_dly[2*MUL_LATENCY-1].d_q[WIDTH-1:0];
    assign x2_s3 = g_sq_dly[MUL_LATENCY-1].d_q[2*WIDTH-1:WIDTH];
    assign xy_s3 = g_sq_dly[MUL_LATENCY-1].d_q[WIDTH-1:0];

    // Stage 3: guard-bit accumulators, wrapping; cleared when the solver finishes.
    logic signed [AW-1:0]    acc_q [NSUM];
    logic signed [WIDTH-1:0] term  [NSUM];

    // Term order matches the accumulator order listed at NSUM.
    always_comb begin
        term[0] = x_s3;
        term[1] = x2_s3;
        term[2] = x3;
        term[3] = x4;
        term[4] = y_s3;
        term[5] = xy_s3;
        term[6] = x2y;
    end

    // Accumulate one aligned sample per valid cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSUM; k++) acc_q[k] <= '0;
        end else if (clear_acc) begin
            for (int k = 0; k < NSUM; k++) acc_q[k] <= '0;
        end else if (s2_valid) begin
            for (int k = 0; k < NSUM; k++) acc_q[k] <= acc_q[k] + AW'(term[k]);
        end
    end

    // Saturated word view of n and every sum; index 0 is n, 1..7 follow the accumulators.
    logic signed [WIDTH-1:0] issue_val [NSUM+1];
    logic [NSUM:0]           issue_hit;
    logic signed [SAT_W-1:0] n_wide;

    // Clamp each sum to one word for hand-off.
    always_comb begin
        n_wide       = SAT_W'($signed({1'b0, count_q})) <<< QFRAC;
        issue_val[0] = WIDTH'(sat_trunc(n_wide, WIDTH));
        issue_hit[0] = sat_hit(n_wide, WIDTH);
        for (int k = 1; k <= NSUM; k++) begin
            issue_val[k] = WIDTH'(sat_trunc(SAT_W'(acc_q[k-1]), WIDTH));
            issue_hit[k] = sat_hit(SAT_W'(acc_q[k-1]), WIDTH);
        end
    end

    // A is a Hankel matrix of the power sums: A[r][c] = S(x^(r+c)); B[r] = S(x^r * y).
    logic [9*WIDTH-1:0] issue_a;
    logic [3*WIDTH-1:0] issue_b;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            for (gj = 0; gj < 3; gj++) begin : g_col
                assign issue_a[(gi*3+gj)*WIDTH +: WIDTH] = issue_val[gi+gj];
            end
            assign issue_b[gi*WIDTH +: WIDTH] = issue_val[5+gi];
        end
    endgenerate

    // Batch sequencing: accept, let the pipeline drain, publish, then wait for the solver.
    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        count_d   = count_q;
        start_d   = 1'b0;
        sat_d     = sat_q | mul_sat;
        a_d       = a_q;
        b_d       = b_q;
        clear_acc = 1'b0;
        if (fire) begin
            count_d = count_q + 1'b1;
        end
        case (state_q)
            S_ACCUM: begin
                if (fire && (s_last || (count_d == CW'(MAX_SAMPLES)))) begin
                    state_d = S_DRAIN;
                    drain_d = DW'(PIPE_LAT - 1);
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) state_d = S_ISSUE;
                else               drain_d = drain_q - 1'b1;
            end
            S_ISSUE: begin
                a_d     = issue_a;
                b_d     = issue_b;
                start_d = 1'b1;
                if (|issue_hit) sat_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (solve_done) begin
                    state_d   = S_ACCUM;
                    count_d   = '0;
                    sat_d     = 1'b0;
                    clear_acc = 1'b1;
                end
            end
            default: state_d = S_ACCUM;
        endcase
        ready_d = (state_d == S_ACCUM);
    end

    // Control and hand-off registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ACCUM;
            drain_q <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            start_q <= 1'b0;
            sat_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            count_q <= count_d;
            ready_q <= ready_d;
            start_q <= start_d;
            sat_q   <= sat_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign s_ready      = ready_q;
    assign solve_start  = start_q;
    assign busy         = (state_q != S_ACCUM);
    assign sat_flag     = sat_q;
    assign sample_count = count_q;
    assign A_flat       = a_q;
    assign B_flat       = b_q;

endmodule

// File: tb/tb_lsm_normal_eq_builder.sv
// Scoreboard bench for lsm_normal_eq_builder: expected A/B pushed at stimulus time, checked on solve_start.
module tb_lsm_normal_eq_builder;
    localparam int W        = 32;
    localparam int ML       = 1;
    localparam int MAXS     = 4096;
    localparam int CW       = $clog2(MAXS + 1);
    localparam int PIPE_LAT = 2 * ML + 1;
    localparam int Q1       = 65536;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s_valid, s_last, solve_done;
    logic              s_ready, solve_start, busy, sat_flag;
    logic signed [W-1:0] s_x, s_y;
    logic [9*W-1:0]    A_flat;
    logic [3*W-1:0]    B_flat;
    logic [CW-1:0]     sample_count;

    lsm_normal_eq_builder #(.WIDTH(W), .MUL_LATENCY(ML), .GUARD(8), .MAX_SAMPLES(MAXS)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_x(s_x), .s_y(s_y), .s_last(s_last), .A_flat(A_flat), .B_flat(B_flat),
        .solve_start(solve_start), .solve_done(solve_done), .busy(busy),
        .sat_flag(sat_flag), .sample_count(sample_count));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int last_beat_cyc = 0;
    int exp_starts = 0;
    bit model_sat;

    int bx[$];
    int by[$];
    logic [9*W-1:0] exp_a_q[$];
    logic [3*W-1:0] exp_b_q[$];
    bit             exp_s_q[$];
    int             exp_c_q[$];
    logic [9*W-1:0] last_a;
    logic [3*W-1:0] last_b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic.
    function automatic int sat32(input longint v);
        if (v > 64'sd2147483647) begin
            model_sat = 1'b1;
            return 32'sh7FFFFFFF;
        end
        if (v < -64'sd2147483648) begin
            model_sat = 1'b1;
            return 32'sh80000000;
        end
        return int'(v);
    endfunction

    function automatic int smul(input int a, input int b);
        longint p;
        p = (longint'(a) * longint'(b)) >>> 16;
        return sat32(p);
    endfunction

    function automatic longint wrap40(input longint v);
        return (v <<< 24) >>> 24;
    endfunction

    task automatic push_exp(input logic [9*W-1:0] a, input logic [3*W-1:0] b, input bit s, input int c);
        exp_a_q.push_back(a);
        exp_b_q.push_back(b);
        exp_s_q.push_back(s);
        exp_c_q.push_back(c);
        last_a = a;
        last_b = b;
        exp_starts++;
    endtask

    task automatic push_const(input int av[9], input int bv[3], input int c);
        logic [9*W-1:0] a;
        logic [3*W-1:0] b;
        for (int k = 0; k < 9; k++) a[k*W +: W] = av[k];
        for (int k = 0; k < 3; k++) b[k*W +: W] = bv[k];
        push_exp(a, b, 1'b0, c);
    endtask

    task automatic push_model();
        longint acc[7];
        int     vals[8];
        int     x, y, x2, xy, x3, x4, x2y;
        logic [9*W-1:0] a;
        logic [3*W-1:0] b;
        model_sat = 1'b0;
        for (int k = 0; k < 7; k++) acc[k] = 0;
        for (int i = 0; i < bx.size(); i++) begin
            x = bx[i];
            y = by[i];
            x2  = smul(x, x);
            xy  = smul(x, y);
            x3  = smul(x2, x);
            x4  = smul(x2, x2);
            x2y = smul(x2, y);
            acc[0] = wrap40(acc[0] + x);
            acc[1] = wrap40(acc[1] + x2);
            acc[2] = wrap40(acc[2] + x3);
            acc[3] = wrap40(acc[3] + x4);
            acc[4] = wrap40(acc[4] + y);
            acc[5] = wrap40(acc[5] + xy);
            acc[6] = wrap40(acc[6] + x2y);
        end
        vals[0] = sat32(longint'(bx.size()) <<< 16);
        for (int k = 0; k < 7; k++) vals[k+1] = sat32(acc[k]);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) a[(r*3+c)*W +: W] = vals[r+c];
            b[r*W +: W] = vals[5+r];
        end
        push_exp(a, b, model_sat, bx.size());
    endtask

    task automatic load(input int x, input int y);
        bx.push_back(x);
        by.push_back(y);
    endtask

    task automatic send_batch(input bit rand_valid, input bit with_last);
        int  sent  = 0;
        int  guard = 0;
        bit  ready_now;
        while (sent < bx.size()) begin
            @(negedge clk);
            s_valid   = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            s_x       = bx[sent];
            s_y       = by[sent];
            s_last    = with_last && (sent == bx.size() - 1);
            ready_now = s_ready;
            @(posedge clk);
            if (s_valid && ready_now) begin
                sent++;
                last_beat_cyc = cyc + 1;
            end
            guard++;
            if (guard > 20000) begin
                check_val("send_timeout", sent, bx.size());
                break;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_start();
        int g = 0;
        while (start_cnt < exp_starts && g < 300) begin
            @(negedge clk);
            g++;
        end
        check_val("start_seen", start_cnt, exp_starts);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        solve_done = 1'b1;
        @(negedge clk);
        solve_done = 1'b0;
    endtask

    task automatic check_released();
        check_val("rel_sat_flag", sat_flag, 1'b0);
        check_val("rel_count", sample_count, 0);
        check_val("rel_s_ready", s_ready, 1'b1);
        check_val("rel_busy", busy, 1'b0);
    endtask

    // Scoreboard consumer: compare the published matrices at each solver start.
    always @(negedge clk) begin
        if (rst_n && solve_start) begin
            start_cnt++;
            start_cyc = cyc;
            check_val("sb_nonempty", exp_a_q.size() > 0, 1'b1);
            if (exp_a_q.size() > 0) begin
                check_val("A_flat", A_flat, exp_a_q.pop_front());
                check_val("B_flat", B_flat, exp_b_q.pop_front());
                check_val("sat_flag", sat_flag, exp_s_q.pop_front());
                check_val("sample_count", sample_count, exp_c_q.pop_front());
                $display("[TB] batch %0d issued at cycle %0d", start_cnt, cyc);
            end
        end
    end

    initial begin
        int  av[9];
        int  bv[3];
        bit  ready_seen;
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; solve_done = 1'b0;
        s_x = '0; s_y = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_s_ready", s_ready, 1'b0);
        check_val("rst_start", solve_start, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_sat", sat_flag, 1'b0);
        check_val("rst_count", sample_count, 0);
        check_val("rst_A", A_flat, 0);
        check_val("rst_B", B_flat, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("ready_after_reset", s_ready, 1'b1);

        // x = 1,2,3 ; y = 2,4,6
        bx.delete(); by.delete();
        load(1*Q1, 2*Q1); load(2*Q1, 4*Q1); load(3*Q1, 6*Q1);
        av = '{3*Q1, 6*Q1, 14*Q1, 6*Q1, 14*Q1, 36*Q1, 14*Q1, 36*Q1, 98*Q1};
        bv = '{12*Q1, 28*Q1, 72*Q1};
        push_const(av, bv, 3);
        send_batch(1'b0, 1'b1);
        wait_start();
        check_val("start_latency", start_cyc - last_beat_cyc, PIPE_LAT + 1);
        repeat (5) @(negedge clk);
        check_val("start_once", start_cnt, exp_starts);
        check_val("wait_busy", busy, 1'b1);
        pulse_done();
        check_released();

        // single sample x = -2, y = 0.5
        bx.delete(); by.delete();
        load(-2*Q1, Q1/2);
        av = '{Q1, -2*Q1, 4*Q1, -2*Q1, 4*Q1, -8*Q1, 4*Q1, -8*Q1, 16*Q1};
        bv = '{Q1/2, -Q1, 2*Q1};
        push_const(av, bv, 1);
        send_batch(1'b0, 1'b1);
        wait_start();
        pulse_done();

        // x = 200 saturates the power chain; hold the solver off for 50 cycles
        bx.delete(); by.delete();
        load(200*Q1, Q1);
        push_model();
        send_batch(1'b0, 1'b1);
        wait_start();
        ready_seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            ready_seen |= s_ready;
        end
        check_val("hold_s_ready", ready_seen, 1'b0);
        check_val("hold_A", A_flat, last_a);
        check_val("hold_B", B_flat, last_b);
        check_val("hold_sat", sat_flag, 1'b1);
        check_val("hold_x4_sat", A_flat[8*W +: W], 32'h7FFFFFFF);
        pulse_done();
        check_released();
        pulse_done();  // ignored while accumulating
        check_val("idle_done_busy", busy, 1'b0);
        check_val("idle_done_ready", s_ready, 1'b1);
        check_val("idle_done_starts", start_cnt, exp_starts);

        // 10 samples with a random valid pattern
        bx.delete(); by.delete();
        for (int i = 0; i < 10; i++)
            load(int'($urandom_range(0, 6*Q1)) - 3*Q1, int'($urandom_range(0, 6*Q1)) - 3*Q1);
        push_model();
        send_batch(1'b1, 1'b1);
        wait_start();
        pulse_done();

        // MAX_SAMPLES beats without s_last forces the issue
        bx.delete(); by.delete();
        for (int i = 0; i < MAXS; i++)
            load(int'($urandom_range(0, 2*Q1)) - Q1, int'($urandom_range(0, 2*Q1)) - Q1);
        push_model();
        send_batch(1'b0, 1'b0);
        check_val("max_ready_low", s_ready, 1'b0);
        wait_start();
        pulse_done();

        // reset while draining: nothing issues, next batch starts clean
        bx.delete(); by.delete();
        load(5*Q1, Q1); load(7*Q1, -Q1); load(-3*Q1, 2*Q1);
        send_batch(1'b0, 1'b1);
        check_val("drain_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_A", A_flat, 0);
        check_val("mid_rst_B", B_flat, 0);
        check_val("mid_rst_busy", busy, 1'b0);
        check_val("mid_rst_count", sample_count, 0);
        check_val("mid_rst_ready", s_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        start_cnt  = 0;
        exp_starts = 0;
        repeat (2) @(negedge clk);
        bx.delete(); by.delete();
        for (int i = 0; i < 4; i++)
            load(int'($urandom_range(0, 4*Q1)) - 2*Q1, int'($urandom_range(0, 4*Q1)) - 2*Q1);
        push_model();
        send_batch(1'b0, 1'b1);
        wait_start();
        pulse_done();
        check_released();

        check_val("sb_drained", exp_a_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
